// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned CTRL_W          = 32;
  localparam int unsigned CTRL_SEND_BIT   = 0;
  localparam int unsigned CTRL_RXNEW_BIT  = 1;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    CLEAR = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled, ticks on the last count.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 1042
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick marks the final cycle of a bit period.
  assign tick_o = en_i && (cnt_q == LAST_CNT);

  // Next count: clear wins, wrap at the bit boundary, hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST_CNT) cnt_d = '0;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 transmit engine driven by the control register SEND bit; clears SEND via write port 2.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 1042,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr2_o,
  output logic [CTRL_W-1:0] in2_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [CTRL_W-1:0] SEND_MASK = CTRL_W'(1) << CTRL_SEND_BIT;

  tx_state_t             state_q;
  logic [DATA_W-1:0]     shift_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  wr2_q;
  logic [CTRL_W-1:0]     in2_q;

  logic baud_en;
  logic baud_clr;
  logic tick;

  // Baud counter runs only while a line bit is being driven; held clear in IDLE.
  assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clr = (state_q == IDLE);

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (baud_en),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  // Frame sequencer with registered line, busy and write-back outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      ctrl_q    <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr2_q     <= 1'b0;
      in2_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          wr2_q  <= 1'b0;
          in2_q  <= '0;
          if (ctrl_i[CTRL_SEND_BIT]) begin
            shift_q   <= data_i;
            ctrl_q    <= ctrl_i;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            wr2_q   <= 1'b1;
            in2_q   <= ctrl_q & ~SEND_MASK;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          wr2_q   <= 1'b0;
          in2_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          wr2_q   <= 1'b0;
          in2_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign wr2_o  = wr2_q;
  assign in2_o  = in2_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a two-port control register model.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int unsigned BAUD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl_reg = 32'h0;
  logic [7:0]  data = 8'h00;
  logic        wr2;
  logic [31:0] in2;
  logic        tx;
  logic        busy;

  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_val = 32'h0;
  logic        auto_rw = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ctrl;
    logic [7:0]  data;
    logic [31:0] exp_in2;
    bit          disturb;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_i (ctrl_reg),
    .data_i (data),
    .wr2_o  (wr2),
    .in2_o  (in2),
    .tx_o   (tx),
    .busy_o (busy)
  );

  // Control register: CPU port 1 has priority over the engine's port 2.
  always @(posedge clk) begin
    if (cpu_wr)     ctrl_reg <= cpu_val;
    else if (wr2)   ctrl_reg <= auto_rw ? (in2 | 32'h1) : in2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // CPU write of one cycle; returns at the negedge before the DUT's sampling edge.
  task automatic cpu_write(input logic [31:0] v);
    @(negedge clk);
    cpu_val = v;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_wr  = 1'b0;
  endtask

  // Checks one full frame starting at the next posedge (edge E) through the idle cycle.
  task automatic check_frame(input logic [7:0] d, input logic [31:0] exp_in2,
                             input bit disturb, input bit auto_mode);
    logic exp_bit;
    int k;
    k = 0;
    for (int b = 0; b < int'(UART_FRAME_BITS); b++) begin
      for (int c = 0; c < int'(BAUD); c++) begin
        @(negedge clk);
        cpu_wr = 1'b0;
        if (b == 0)      exp_bit = 1'b0;
        else if (b == 9) exp_bit = 1'b1;
        else             exp_bit = d[b-1];
        chk("tx_bit", {31'h0, tx}, {31'h0, exp_bit});
        chk("busy_frame", {31'h0, busy}, 32'h1);
        chk("wr2_frame", {31'h0, wr2}, 32'h0);
        chk("in2_frame", in2, 32'h0);
        if (disturb && k == 6) begin
          data    = 8'hFF;
          cpu_val = 32'h0;
          cpu_wr  = 1'b1;
        end
        if (disturb && k == 18) begin
          cpu_val = 32'h3;
          cpu_wr  = 1'b1;
        end
        k++;
      end
    end
    @(negedge clk);
    cpu_wr = 1'b0;
    chk("wr2_pulse", {31'h0, wr2}, 32'h1);
    chk("in2_value", in2, exp_in2);
    chk("busy_clear", {31'h0, busy}, 32'h1);
    chk("tx_clear", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("wr2_after", {31'h0, wr2}, 32'h0);
    chk("in2_after", in2, 32'h0);
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("tx_idle", {31'h0, tx}, 32'h1);
    chk("ctrl_reg_wb", ctrl_reg, auto_mode ? (exp_in2 | 32'h1) : exp_in2);
  endtask

  initial begin
    vecs[0] = '{ctrl: 32'h0000_0001, data: 8'hA5, exp_in2: 32'h0000_0000, disturb: 1'b0};
    vecs[1] = '{ctrl: 32'h0000_0003, data: 8'h3C, exp_in2: 32'h0000_0002, disturb: 1'b0};
    vecs[2] = '{ctrl: 32'h0000_0003, data: 8'h3C, exp_in2: 32'h0000_0002, disturb: 1'b1};
    vecs[3] = '{ctrl: 32'hFFFF_FFFF, data: 8'h00, exp_in2: 32'hFFFF_FFFE, disturb: 1'b0};
    vecs[4] = '{ctrl: 32'h8000_0001, data: 8'h81, exp_in2: 32'h8000_0000, disturb: 1'b0};

    // Power-up reset.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", {31'h0, tx}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_wr2", {31'h0, wr2}, 32'h0);
      chk("rst_in2", in2, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      data = vecs[i].data;
      cpu_write(vecs[i].ctrl);
      chk("idle_before", {31'h0, busy}, 32'h0);
      check_frame(vecs[i].data, vecs[i].exp_in2, vecs[i].disturb, 1'b0);
      repeat (8) begin
        @(negedge clk);
        chk("no_extra_wr2", {31'h0, wr2}, 32'h0);
        chk("stay_idle", {31'h0, busy}, 32'h0);
      end
    end

    // Reset during data bit 3 aborts, then the frame restarts.
    data = 8'h00;
    cpu_write(32'h1);
    repeat (18) @(negedge clk);
    chk("bit3_low", {31'h0, tx}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("abort_tx", {31'h0, tx}, 32'h1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_wr2", {31'h0, wr2}, 32'h0);
      chk("abort_tx_hold", {31'h0, tx}, 32'h1);
    end
    chk("send_kept", {31'h0, ctrl_reg[0]}, 32'h1);
    rst = 1'b0;
    check_frame(8'h00, 32'h0, 1'b0, 1'b0);

    // Back-to-back frames with SEND rewritten by the CPU on each write-back.
    data = 8'h5A;
    cpu_write(32'h1);
    auto_rw = 1'b1;
    check_frame(8'h5A, 32'h0, 1'b0, 1'b1);
    auto_rw = 1'b0;
    check_frame(8'h5A, 32'h0, 1'b0, 1'b0);
    repeat (8) begin
      @(negedge clk);
      chk("b2b_end_wr2", {31'h0, wr2}, 32'h0);
      chk("b2b_end_busy", {31'h0, busy}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit engine that sits directly downstream of the peripheral control register. It watches the register's send bit, serialises the byte held in the data register as an 8N1 frame, and writes the register back through its second write port to clear the send bit when the frame is complete. The CPU side owns write port 1; this block owns write port 2.

## Interface
Parameters:
- BAUD_DIV, 1042, clock cycles per UART bit (10 MHz / 9600 baud); legal range ≥ 2
- DATA_W, 8, payload bits per frame; fixed at 8 for this release

Ports:
- clk_i  in  1  system clock (10 MHz nominal)
- rst_i  in  1  reset, asynchronous, active-high
- ctrl_i  in  32  current control register contents (register out_o); bit 0 = SEND
- data_i  in  8  byte to transmit (data register low byte)
- wr2_o  out  1  write strobe to control register port 2; one-cycle pulse
- in2_o  out  32  write-back value for control register port 2
- tx_o  out  1  serial line; idle high
- busy_o  out  1  frame in progress

## Operation
- States: IDLE, START, DATA, STOP, CLEAR.
- IDLE: tx_o=1, busy_o=0. If ctrl_i[0]=1, latch data_i into shift register and ctrl_i into ctrl_q, clear bit counter and baud counter, then go to START.
- START: tx_o=0 for BAUD_DIV cycles, then go to DATA.
- DATA: tx_o=shift[0], LSB first; each bit is held BAUD_DIV cycles, then the register shifts right. After 8 bits, go to STOP.
- STOP: tx_o=1 for BAUD_DIV cycles, then go to CLEAR.
- CLEAR: exactly one cycle. wr2_o=1, in2_o={ctrl_q[31:1],1'b0}, which clears SEND and preserves every other bit as latched at start. Then go to IDLE.
- in2_o=0 whenever wr2_o=0.
- data_i and ctrl_i changes mid-frame have no effect on the frame in flight.
- Baud counter counts 0..BAUD_DIV-1 and is $clog2(BAUD_DIV) bits wide. It wraps to 0 at the bit boundary.
- Bit counter is 3 bits and counts 0..7. At count 7 with the boundary reached, the FSM leaves DATA.
- Simultaneous events:
  - CPU re-sets SEND in the same cycle as wr2_o: the control register's port priority decides the outcome. If SEND reads 1 in IDLE, a new frame starts.
  - While busy, SEND is ignored. No queueing.

## Timing
- Reset values: tx_o=1, busy_o=0, wr2_o=0, in2_o=0, state=IDLE, all counters 0. Outputs take these values immediately on rst_i rise.
- Reset mid-frame aborts the frame: tx_o returns high at once and no write-back occurs. SEND stays set in the register, so the frame restarts after reset deasserts.
- Edge E samples ctrl_i[0]=1 in IDLE. At E+1, tx_o=0 and busy_o=1.
- Frame length is 10·BAUD_DIV cycles: start, 8 data, stop.
- wr2_o pulses in the cycle immediately after the stop bit ends (cycle 10·BAUD_DIV after E+1).
- The control register shows SEND=0 one cycle after the wr2_o pulse. busy_o stays 1 during CLEAR and is 0 the following cycle.
- Back-to-back frames: the minimum gap from stop-bit end to the next start bit is 2 cycles.
- All outputs are registered; no combinational path from ctrl_i or data_i to any output.

## Structure
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP, CLEAR}
  - CTRL_SEND_BIT=0 and CTRL_RXNEW_BIT=1 index constants
  - UART_FRAME_BITS=10
- One sub-module, uart_baud_gen: counter with enable and synchronous clear, emitting a one-cycle tick_o at count BAUD_DIV-1. The FSM advances only on tick_o.
- Expected size is roughly 150–200 lines of RTL in total.

## Test plan
Run with BAUD_DIV=4 for simulation.
- Reset at power-up → tx_o=1, busy_o=0, wr2_o=0, in2_o=0 throughout reset.
- ctrl_i=32'h0000_0001, data_i=8'hA5 → tx_o shows 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles. Then a single-cycle wr2_o with in2_o=32'h0000_0000.
- ctrl_i=32'h0000_0003, data_i=8'h3C → in2_o=32'h0000_0002 at write-back; bit 1 preserved.
- Change data_i to 8'hFF and toggle ctrl_i mid-frame → transmitted bits still match the latched 8'h3C; exactly one wr2_o pulse.
- Assert rst_i during DATA bit 3 → tx_o=1 immediately, no wr2_o. After release with SEND still 1, a full frame restarts from the start bit.
- Hold SEND high continuously by emulating a CPU rewrite on each wr2_o → back-to-back frames with a 2-cycle high gap; busy_o low for exactly 1 cycle between frames.
